// File: rtl/lcd_cmd_arbiter.sv
// Round-robin arbiter that lets several command sources share one character-LCD driver.
// Optional build macro LCD_ARB_TIMEOUT_EN adds WAIT_BUSY/WAIT_DONE timeouts that abort with err.
module lcd_cmd_arbiter #(
    parameter int NREQ    = 2,
    parameter int CMD_W   = 10,
    parameter int ACK_TO  = 16,
    parameter int DONE_TO = 2048
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*CMD_W-1:0] cmd,
    output logic [NREQ-1:0]       ack,
    output logic [NREQ-1:0]       done,
    input  logic                  lcd_busy,
    output logic                  lcd_enable,
    output logic [CMD_W-1:0]      lcd_bus,
    output logic                  arb_busy,
    output logic                  err
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    if (NREQ < 1 || NREQ > 8 || CMD_W < 1 || ACK_TO < 2 || DONE_TO < 2) begin : g_param_check
        $error("lcd_cmd_arbiter: parameter out of range");
    end

    function automatic logic [NREQ-1:0] onehot_f(input logic [PTR_W-1:0] idx);
        logic [NREQ-1:0] v;
        v = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (idx == PTR_W'(i)) begin
                v[i] = 1'b1;
            end else begin
                v[i] = v[i];
            end
        end
        return v;
    endfunction

    logic [1:0]       state_r;
    logic [PTR_W-1:0] rr_ptr_r;
    logic [PTR_W-1:0] win_r;
    logic [NREQ-1:0]  ack_r;
    logic [NREQ-1:0]  done_r;
    logic             lcd_enable_r;
    logic [CMD_W-1:0] lcd_bus_r;
    logic             arb_busy_r;

    logic [NREQ-1:0]  req_rot_s;
    logic             found_s;
    logic [PTR_W-1:0] win_s;
    logic [PTR_W-1:0] next_ptr_s;
    logic [CMD_W-1:0] sel_cmd_s;
    int               win_int_s;
    int               nxt_int_s;

`ifdef LCD_ARB_TIMEOUT_EN
    localparam int MAX_TO = (ACK_TO > DONE_TO) ? ACK_TO : DONE_TO;
    localparam int TMR_W  = (MAX_TO > 2) ? $clog2(MAX_TO) : 1;
    logic [TMR_W-1:0] timer_r;
    logic             err_r;
`endif

    // Round-robin pick: first requester at or after rr_ptr, plus its command and the following pointer.
    always_comb begin
        req_rot_s  = NREQ'({req, req} >> rr_ptr_r);
        found_s    = 1'b0;
        win_s      = '0;
        win_int_s  = 0;
        nxt_int_s  = 0;
        sel_cmd_s  = '0;
        next_ptr_s = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found_s && req_rot_s[i]) begin
                found_s   = 1'b1;
                win_int_s = int'(rr_ptr_r) + i;
                if (win_int_s >= NREQ) begin
                    win_int_s = win_int_s - NREQ;
                end else begin
                    win_int_s = win_int_s;
                end
                win_s = PTR_W'(win_int_s);
            end else begin
                found_s = found_s;
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (win_s == PTR_W'(i)) begin
                sel_cmd_s = cmd[i*CMD_W +: CMD_W];
            end else begin
                sel_cmd_s = sel_cmd_s;
            end
        end
        nxt_int_s = int'(win_s) + 1;
        if (nxt_int_s >= NREQ) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = PTR_W'(nxt_int_s);
        end
    end

    // Arbitration FSM with registered strobes, grant bookkeeping and the optional timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            rr_ptr_r     <= '0;
            win_r        <= '0;
            ack_r        <= '0;
            done_r       <= '0;
            lcd_enable_r <= 1'b0;
            lcd_bus_r    <= '0;
            arb_busy_r   <= 1'b0;
`ifdef LCD_ARB_TIMEOUT_EN
            timer_r      <= '0;
            err_r        <= 1'b0;
`endif
        end else begin
            ack_r        <= '0;
            done_r       <= '0;
            lcd_enable_r <= 1'b0;
`ifdef LCD_ARB_TIMEOUT_EN
            err_r        <= 1'b0;
`endif
            case (state_r)
                ST_IDLE: begin
                    // The driver reports busy during its own init, so nothing is granted until it is idle.
                    if (!lcd_busy && found_s) begin
                        state_r      <= ST_ISSUE;
                        win_r        <= win_s;
                        rr_ptr_r     <= next_ptr_s;
                        lcd_bus_r    <= sel_cmd_s;
                        lcd_enable_r <= 1'b1;
                        ack_r        <= onehot_f(win_s);
                        arb_busy_r   <= 1'b1;
                    end else begin
                        arb_busy_r   <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    state_r <= ST_WAIT_BUSY;
`ifdef LCD_ARB_TIMEOUT_EN
                    timer_r <= '0;
`endif
                end
                ST_WAIT_BUSY: begin
                    if (lcd_busy) begin
                        state_r <= ST_WAIT_DONE;
`ifdef LCD_ARB_TIMEOUT_EN
                        timer_r <= '0;
                    end else if (timer_r == TMR_W'(ACK_TO - 1)) begin
                        state_r    <= ST_IDLE;
                        done_r     <= onehot_f(win_r);
                        err_r      <= 1'b1;
                        arb_busy_r <= 1'b0;
                    end else begin
                        timer_r <= timer_r + TMR_W'(1);
`else
                    end else begin
                        state_r <= ST_WAIT_BUSY;
`endif
                    end
                end
                ST_WAIT_DONE: begin
                    if (!lcd_busy) begin
                        state_r    <= ST_IDLE;
                        done_r     <= onehot_f(win_r);
                        arb_busy_r <= 1'b0;
`ifdef LCD_ARB_TIMEOUT_EN
                    end else if (timer_r == TMR_W'(DONE_TO - 1)) begin
                        state_r    <= ST_IDLE;
                        done_r     <= onehot_f(win_r);
                        err_r      <= 1'b1;
                        arb_busy_r <= 1'b0;
                    end else begin
                        timer_r <= timer_r + TMR_W'(1);
`else
                    end else begin
                        state_r <= ST_WAIT_DONE;
`endif
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    arb_busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign ack        = ack_r;
    assign done       = done_r;
    assign lcd_enable = lcd_enable_r;
    assign lcd_bus    = lcd_bus_r;
    assign arb_busy   = arb_busy_r;
`ifdef LCD_ARB_TIMEOUT_EN
    assign err        = err_r;
`else
    assign err        = 1'b0;
`endif

endmodule
